// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: round-robin merge of N FWFT source FIFOs into one registered output stream.
// Define RR_ARB_BURST_LIMIT_EN to cap each grant at MAX_BURST pops unless the channel holds.
module rr_stream_arbiter #(
  parameter int CHANNELS = 5,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST = 16,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           BUS_CLK,
  input  logic                           BUS_RST_N,
  input  logic [CHANNELS-1:0]            ENABLE,
  input  logic [CHANNELS-1:0]            WRITE_REQ,
  input  logic [CHANNELS-1:0]            HOLD_REQ,
  input  logic [CHANNELS*DATA_WIDTH-1:0] DATA_IN,
  output logic [CHANNELS-1:0]            READ_GRANT,
  input  logic                           OUT_READY,
  output logic                           OUT_VALID,
  output logic [DATA_WIDTH-1:0]          OUT_DATA,
  output logic [CW-1:0]                  OUT_CHANNEL,
  output logic                           BUSY
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [CW-1:0] g, last, pick, idx;
  logic [CHANNELS-1:0] req;
  logic [DATA_WIDTH-1:0] words [CHANNELS];
  logic pop, rel, burst_done;
  if (CHANNELS < 2 || CHANNELS > 32 || MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_param
    $error("rr_stream_arbiter: parameter out of range");
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_words
    assign words[i] = DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
  end
  assign req = ENABLE & (WRITE_REQ | HOLD_REQ);
  // Scan from farthest to nearest so the channel right after 'last' wins.
  always_comb begin
    pick = last;
    idx = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      idx = CW'((int'(last) + k) % CHANNELS);
      if (req[idx]) pick = idx;
    end
  end
  assign pop = BUS_RST_N && state == GRANT && WRITE_REQ[g] && ENABLE[g] && (!OUT_VALID || OUT_READY);
  assign READ_GRANT = {CHANNELS{pop}} & (CHANNELS'(1) << g);
  assign rel = state == GRANT && !HOLD_REQ[g] && ((!pop && !WRITE_REQ[g]) || !ENABLE[g] || burst_done);
  assign BUSY = state == GRANT;
`ifdef RR_ARB_BURST_LIMIT_EN
  logic [7:0] burst_cnt;
  assign burst_done = pop && int'(burst_cnt) >= MAX_BURST - 1;
`else
  assign burst_done = 1'b0;
`endif
  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      state <= IDLE;
      g <= '0;
      last <= CW'(CHANNELS - 1);
      OUT_VALID <= 1'b0;
      OUT_DATA <= '0;
      OUT_CHANNEL <= '0;
`ifdef RR_ARB_BURST_LIMIT_EN
      burst_cnt <= '0;
`endif
    end else begin
      if (state == IDLE && |req) begin
        state <= GRANT;
        g <= pick;
`ifdef RR_ARB_BURST_LIMIT_EN
        burst_cnt <= '0;
`endif
      end else if (rel) begin
        state <= IDLE;
        last <= g;
      end
`ifdef RR_ARB_BURST_LIMIT_EN
      if (pop && int'(burst_cnt) < MAX_BURST && burst_cnt != 8'hff) burst_cnt <= burst_cnt + 8'd1;
`endif
      if (pop) begin
        OUT_VALID <= 1'b1;
        OUT_DATA <= words[g];
        OUT_CHANNEL <= g;
      end else if (OUT_READY) OUT_VALID <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_stream_arbiter.sv
// tb_rr_stream_arbiter: directed checks of rotation, backpressure, hold, burst, disable and reset.
module tb_rr_stream_arbiter;
  logic BUS_CLK, BUS_RST_N, OUT_READY, OUT_VALID, BUSY;
  logic [4:0] ENABLE, WRITE_REQ, HOLD_REQ, READ_GRANT;
  logic [159:0] DATA_IN;
  logic [31:0] OUT_DATA;
  logic [2:0] OUT_CHANNEL;
  int vectors = 0, errors = 0;
  int hd [5], cnt [5];
  logic [31:0] base [5];
  logic [31:0] rx_d [$], rx_c [$], exp_d [$], exp_c [$];
  bit busy_q [$];
  bit held = 0;
  logic [31:0] held_data;
  logic [4:0] s_rg;
  logic s_busy, s_ov;
  logic [31:0] s_data;
  logic [2:0] s_ch;
  int first_b, last_b, gaps, run, r1, r2, n;
  bit saw;

  rr_stream_arbiter #(.CHANNELS(5), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N), .ENABLE(ENABLE), .WRITE_REQ(WRITE_REQ),
    .HOLD_REQ(HOLD_REQ), .DATA_IN(DATA_IN), .READ_GRANT(READ_GRANT), .OUT_READY(OUT_READY),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_CHANNEL(OUT_CHANNEL), .BUSY(BUSY)
  );

  initial BUS_CLK = 0;
  always #5 BUS_CLK = ~BUS_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int c = 0; c < 5; c++) begin
      WRITE_REQ[c] = hd[c] < cnt[c];
      DATA_IN[c*32 +: 32] = base[c] + 32'(hd[c]);
    end
  endtask

  task automatic load(input int c, input int words, input logic [31:0] b);
    base[c] = b;
    hd[c] = 0;
    cnt[c] = words;
    refresh();
  endtask

  task automatic push_exp(input int c, input logic [31:0] b, input int words);
    for (int k = 0; k < words; k++) begin
      exp_d.push_back(b + 32'(k));
      exp_c.push_back(32'(c));
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, 32'(rx_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < rx_d.size() && i < exp_d.size(); i++) begin
      chk({tag, "_data"}, rx_d[i], exp_d[i]);
      chk({tag, "_chan"}, rx_c[i], exp_c[i]);
    end
    rx_d.delete(); rx_c.delete(); exp_d.delete(); exp_c.delete();
  endtask

  // One clock: sample outputs at the falling edge, then let the source FIFOs pop after the rise.
  task automatic tick();
    @(negedge BUS_CLK);
    s_rg = READ_GRANT; s_busy = BUSY; s_ov = OUT_VALID; s_data = OUT_DATA; s_ch = OUT_CHANNEL;
    busy_q.push_back(BUSY);
    chk("onehot", 32'($countones(s_rg) <= 1), 32'd1);
    if (held) begin
      chk("stall_data", OUT_DATA, held_data);
      chk("stall_valid", 32'(OUT_VALID), 32'd1);
    end
    if (OUT_VALID && !OUT_READY) chk("stall_grant", 32'(s_rg), 32'd0);
    held = BUS_RST_N && OUT_VALID && !OUT_READY;
    held_data = OUT_DATA;
    if (BUS_RST_N && OUT_VALID && OUT_READY) begin
      rx_d.push_back(OUT_DATA);
      rx_c.push_back(32'(OUT_CHANNEL));
    end
    @(posedge BUS_CLK);
    #1;
    for (int c = 0; c < 5; c++) if (s_rg[c]) hd[c]++;
    refresh();
  endtask

  initial begin
    ENABLE = '1; HOLD_REQ = '0; OUT_READY = 1; BUS_RST_N = 0; DATA_IN = '0; WRITE_REQ = '0;
    for (int c = 0; c < 5; c++) load(c, 1, 32'hA0 + 32'(c));
    repeat (3) begin
      tick();
      chk("rst_grant", 32'(s_rg), 32'd0);
      chk("rst_valid", 32'(s_ov), 32'd0);
    end
    BUS_RST_N = 1;
    tick();
    chk("first_busy", 32'(s_busy), 32'd0);
    chk("first_valid0", 32'(s_ov), 32'd0);
    tick();
    chk("first_grant", 32'(s_rg), 32'b00001);
    chk("first_valid1", 32'(s_ov), 32'd0);
    tick();
    chk("first_valid2", 32'(s_ov), 32'd1);
    chk("first_data", s_data, 32'hA0);
    chk("first_chan", 32'(s_ch), 32'd0);
    repeat (15) tick();
    for (int c = 0; c < 5; c++) push_exp(c, 32'hA0 + 32'(c), 1);
    compare("reset_drain");

    busy_q.delete();
    load(1, 4, 32'h100); load(3, 4, 32'h300);
    repeat (20) tick();
    push_exp(1, 32'h100, 4); push_exp(3, 32'h300, 4);
    compare("rotation");
    first_b = -1; last_b = -1; gaps = 0;
    for (int i = 0; i < busy_q.size(); i++) if (busy_q[i]) begin
      if (first_b < 0) first_b = i;
      last_b = i;
    end
    for (int i = first_b; i <= last_b && first_b >= 0; i++) if (!busy_q[i]) gaps++;
    chk("rotation_idle_gap", 32'(gaps), 32'd1);

    load(2, 10, 32'h200);
    for (int i = 0; i < 48; i++) begin
      OUT_READY = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    OUT_READY = 1;
    repeat (4) tick();
    push_exp(2, 32'h200, 10);
    compare("backpressure");

    HOLD_REQ = 5'b00001;
    load(0, 0, 32'h50);
    tick();
    tick();
    chk("hold_busy", 32'(s_busy), 32'd1);
    load(4, 8, 32'h400);
    saw = 0;
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 0) begin cnt[0]++; refresh(); end
      tick();
      saw |= s_rg[4];
    end
    chk("hold_no_ch4", 32'(saw), 32'd0);
    HOLD_REQ = '0;
    tick();
    chk("hold_drop_busy", 32'(s_busy), 32'd1);
    chk("hold_drop_grant", 32'(s_rg), 32'd0);
    tick();
    chk("hold_idle", 32'(s_busy), 32'd0);
    tick();
    chk("hold_ch4_grant", 32'(s_rg), 32'b10000);
    repeat (15) tick();
    push_exp(0, 32'h50, 3); push_exp(4, 32'h400, 8);
    compare("hold");

    load(1, 10, 32'h110); load(2, 10, 32'h210);
    repeat (40) tick();
`ifdef RR_ARB_BURST_LIMIT_EN
    run = 4;
`else
    run = 10;
`endif
    r1 = 0; r2 = 0;
    while (r1 < 10 || r2 < 10) begin
      n = (10 - r1 < run) ? 10 - r1 : run;
      push_exp(1, 32'h110 + 32'(r1), n); r1 += n;
      n = (10 - r2 < run) ? 10 - r2 : run;
      push_exp(2, 32'h210 + 32'(r2), n); r2 += n;
    end
    compare("burst");

    load(3, 6, 32'h330); load(4, 2, 32'h440);
    tick();
    tick();
    chk("dis_pop0", 32'(s_rg), 32'b01000);
    tick();
    chk("dis_pop1", 32'(s_rg), 32'b01000);
    ENABLE = 5'b10111;
    tick();
    chk("dis_release_grant", 32'(s_rg), 32'd0);
    chk("dis_release_busy", 32'(s_busy), 32'd1);
    saw = 0;
    repeat (12) begin tick(); saw |= s_rg[3]; end
    chk("dis_no_ch3", 32'(saw), 32'd0);
    chk("dis_left", 32'(cnt[3] - hd[3]), 32'd4);
    push_exp(3, 32'h330, 2); push_exp(4, 32'h440, 2);
    compare("disable");
    ENABLE = '1;
    repeat (12) tick();
    push_exp(3, 32'h332, 4);
    compare("reenable");

    load(1, 6, 32'h160);
    tick();
    tick();
    tick();
    BUS_RST_N = 0;
    tick();
    chk("midrst_grant", 32'(s_rg), 32'd0);
    BUS_RST_N = 1;
    tick();
    chk("midrst_valid", 32'(s_ov), 32'd0);
    chk("midrst_busy", 32'(s_busy), 32'd0);
    repeat (15) tick();
    push_exp(1, 32'h160, 1); push_exp(1, 32'h162, 4);
    compare("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
